// File: rtl/timer_tick_sequencer.sv
// Programs a free-running interval timer over an Avalon-MM master port, then
// acknowledges each timeout interrupt and counts the timeouts in three BCD digits.
module timer_tick_sequencer #(
    parameter logic [31:0] PERIOD = 32'd24999999
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic        timer_irq,
    input  logic        pause,
    input  logic        clear,
    output logic        tick,
    output logic [11:0] bcd_count,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2
);

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    localparam logic [DATA_W-1:0] PERIOD_L  = PERIOD[15:0];
    localparam logic [DATA_W-1:0] PERIOD_H  = PERIOD[31:16];
    localparam logic [DATA_W-1:0] CTRL_WORD = 16'h0007;

    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PL     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PH     = 3'd3;

    typedef enum logic [2:0] {
        INIT_PL,
        INIT_PH,
        INIT_CTRL,
        IDLE,
        ACK,
        GUARD
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 cs_q, cs_d;
    logic                 write_n_q, write_n_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 tick_q, tick_d;
    logic [DIGIT_W-1:0]   units_q, units_d;
    logic [DIGIT_W-1:0]   tens_q, tens_d;
    logic [DIGIT_W-1:0]   hund_q, hund_d;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 is blanked.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= INIT_PL;
            addr_q    <= ADDR_PL;
            cs_q      <= 1'b1;
            write_n_q <= 1'b0;
            wdata_q   <= PERIOD_L;
            tick_q    <= 1'b0;
            units_q   <= '0;
            tens_q    <= '0;
            hund_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            write_n_q <= write_n_d;
            wdata_q   <= wdata_d;
            tick_q    <= tick_d;
            units_q   <= units_d;
            tens_q    <= tens_d;
            hund_q    <= hund_d;
        end
    end

    // Next state, counter update, and bus outputs registered from the next state.
    always_comb begin
        state_d   = state_q;
        tick_d    = 1'b0;
        units_d   = units_q;
        tens_d    = tens_q;
        hund_d    = hund_q;
        addr_d    = '0;
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        wdata_d   = '0;

        case (state_q)
            INIT_PL:   if (!avm_waitrequest) state_d = INIT_PH;
            INIT_PH:   if (!avm_waitrequest) state_d = INIT_CTRL;
            INIT_CTRL: if (!avm_waitrequest) state_d = IDLE;
            IDLE:      if (timer_irq) state_d = ACK;
            ACK: begin
                if (!avm_waitrequest) begin
                    state_d = GUARD;
                    if (!pause) begin
                        tick_d = 1'b1;
                        if (units_q == 4'd9) begin
                            units_d = '0;
                            if (tens_q == 4'd9) begin
                                tens_d = '0;
                                hund_d = (hund_q == 4'd9) ? '0 : DIGIT_W'(hund_q + 4'd1);
                            end else begin
                                tens_d = DIGIT_W'(tens_q + 4'd1);
                            end
                        end else begin
                            units_d = DIGIT_W'(units_q + 4'd1);
                        end
                    end
                end
            end
            // One dead cycle lets the slave's registered irq clear propagate.
            GUARD:     state_d = IDLE;
            default:   state_d = INIT_PL;
        endcase

        if (clear) begin
            units_d = '0;
            tens_d  = '0;
            hund_d  = '0;
        end

        case (state_d)
            INIT_PL: begin
                addr_d = ADDR_PL;   cs_d = 1'b1; write_n_d = 1'b0; wdata_d = PERIOD_L;
            end
            INIT_PH: begin
                addr_d = ADDR_PH;   cs_d = 1'b1; write_n_d = 1'b0; wdata_d = PERIOD_H;
            end
            INIT_CTRL: begin
                addr_d = ADDR_CTRL; cs_d = 1'b1; write_n_d = 1'b0; wdata_d = CTRL_WORD;
            end
            ACK: begin
                addr_d = ADDR_STATUS; cs_d = 1'b1; write_n_d = 1'b0; wdata_d = '0;
            end
            default: ;
        endcase
    end

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_writedata  = wdata_q;
    assign tick           = tick_q;
    assign bcd_count      = {hund_q, tens_q, units_q};
    assign hex0           = seg_decode(units_q);
    assign hex1           = seg_decode(tens_q);
    assign hex2           = seg_decode(hund_q);

endmodule

// File: doc/timer_tick_sequencer.md
TIMER_TICK_SEQUENCER -- requirements
Module: timer_tick_sequencer

Interface
REQ-001 SHALL have parameter PERIOD, default 32'd24999999 (1 s at 25 MHz), the 32-bit timer reload value, written as period_l = PERIOD[15:0] and period_h = PERIOD[31:16].
REQ-002 SHALL have port clk  input  1  system clock; reset_n, asynchronous, active-low, is the only reset.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port avm_address  output  3  word address toward the timer slave.
REQ-005 SHALL have port avm_chipselect  output  1  slave select.
REQ-006 SHALL have port avm_write_n  output  1  active-low write strobe.
REQ-007 SHALL have port avm_writedata  output  16  write data.
REQ-008 SHALL have port avm_waitrequest  input  1  high = current transfer not accepted this cycle.
REQ-009 SHALL have port timer_irq  input  1  level interrupt from the timer (timeout_occurred AND ITO).
REQ-010 SHALL have port pause  input  1  high = acknowledge ticks without counting.
REQ-011 SHALL have port clear  input  1  synchronous count clear.
REQ-012 SHALL have port tick  output  1  one-cycle pulse per counted timeout.
REQ-013 SHALL have port bcd_count  output  12  three BCD digits {hundreds, tens, units}.
REQ-014 SHALL have ports hex0, hex1, hex2  output  7 each  active-low segments {g,f,e,d,c,b,a} for units, tens, hundreds.

Function
REQ-015 SHALL implement FSM states INIT_PL, INIT_PH, INIT_CTRL, IDLE, ACK, GUARD; reset state INIT_PL.
REQ-016 INIT_PL SHALL drive address 2, data PERIOD[15:0]; INIT_PH address 3, data PERIOD[31:16]; INIT_CTRL address 1, data 16'h0007 (ITO, CONT, START); ACK address 0, data 16'h0000.
REQ-017 In INIT_PL, INIT_PH, INIT_CTRL, ACK: chipselect=1, write_n=0; all other states: chipselect=0, write_n=1, address=0, writedata=0.
REQ-018 A transfer SHALL complete on a rising edge with avm_waitrequest=0; while waitrequest=1 the state and all bus outputs SHALL hold unchanged.
REQ-019 Transitions on completion: INIT_PL->INIT_PH->INIT_CTRL->IDLE; ACK->GUARD.
REQ-020 IDLE->ACK when timer_irq=1; irq ignored in all INIT states, ACK and GUARD.
REQ-021 GUARD SHALL last exactly one cycle, then IDLE, so the registered irq clear is seen before re-sampling.
REQ-022 On ACK completion with pause=0: tick=1 for the next cycle and bcd_count increments by 1 in BCD (units 9->0 carries into tens, tens 9->0 into hundreds, 999->000 wraps).
REQ-023 On ACK completion with pause=1: ACK still issued, no tick, count unchanged.
REQ-024 clear=1 SHALL set bcd_count to 000 on the next edge; clear coincident with an increment SHALL win (result 000, tick still pulses).
REQ-025 bcd_count, tick SHALL be registered; hex0..hex2 SHALL be combinational decodes of the registered digits.
REQ-026 Segment codes (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; non-BCD values (A-F) SHALL decode to 7F (blank).
REQ-027 No irq is ever lost or double-counted: exactly one increment per IDLE->ACK entry.

Reset
REQ-028 On reset_n=0: state INIT_PL, bcd_count=000, tick=0, hex0..hex2=40, bus outputs per INIT_PL after release.
REQ-029 Reset mid-transfer (any state) SHALL abort it; after release the full INIT sequence SHALL be reissued from INIT_PL.

Verification
REQ-030 Reset release, waitrequest=0, PERIOD=9 -> writes (2,0009),(3,0000),(1,0007) on three consecutive cycles, then IDLE with chipselect=0.
REQ-031 Model timer asserting irq every 10 cycles for 12 events -> write (0,0000) per event, 12 tick pulses, bcd_count=012, hex0=24, hex1=79, hex2=40.
REQ-032 Preload to 999 via 999 events, one more irq -> bcd_count=000, tick pulses once.
REQ-033 waitrequest held high 3 cycles during INIT_PH and during ACK -> outputs stable across stall, no extra writes, single increment.
REQ-034 pause=1 over 5 irqs -> 5 ACK writes, no tick, count unchanged; clear asserted in the same cycle as an increment -> bcd_count=000.
REQ-035 reset_n pulsed low during ACK -> no increment, count=000, INIT sequence repeated exactly once.
